control_encode: RTL and testbench

CONTROL_ENCODE -- requirements
Module: control_encode

---
 rtl/ldpc_enc_pkg.sv | 17 +
 rtl/enc_cnt.sv | 29 ++
 rtl/control_encode.sv | 121 ++++++++++++
 tb/tb_control_encode.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_enc_pkg.sv
// Shared definitions for the LDPC encoder: frame geometry defaults and the
// control FSM state encoding used by both the controller and the datapath.
package ldpc_enc_pkg;
  localparam int K_WORDS_DEF  = 8;
  localparam int P_CYCLES_DEF = 16;
  localparam int N_WORDS_DEF  = 16;
  localparam int CW_DEF       = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ENC_START = 3'd2,
    ST_ENC       = 3'd3,
    ST_LOAD_OUT  = 3'd4,
    ST_OUT       = 3'd5
  } enc_state_e;
endpackage

// File: rtl/enc_cnt.sv
// Shared frame counter: synchronous clear, enable, and terminal-count flag
// against a per-state limit; wraps to zero when it advances past the limit.
module enc_cnt import ldpc_enc_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/control_encode.sv
// LDPC encoder frame controller: load K message words, run P parity steps,
// then stream N codeword words out with downstream back-pressure.
module control_encode import ldpc_enc_pkg::*; #(
  parameter int K_WORDS  = K_WORDS_DEF,
  parameter int P_CYCLES = P_CYCLES_DEF,
  parameter int N_WORDS  = N_WORDS_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  input  logic          en_din,
  input  logic          out_rdy,
  output logic          load,
  output logic          start_enc,
  output logic          shift_enc,
  output logic [CW-1:0] blk_idx,
  output logic          load_cout,
  output logic          en_out,
  output logic          shift_out,
  output logic          rst_flag,
  output logic          busy,
  output logic          done
);
  localparam logic [CW-1:0] K_LAST = CW'(K_WORDS - 1);
  localparam logic [CW-1:0] P_LAST = CW'(P_CYCLES - 1);
  localparam logic [CW-1:0] N_LAST = CW'(N_WORDS - 1);

  enc_state_e    state_q, state_d;
  logic          done_q, done_d;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_term, cnt;

  enc_cnt #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign done = done_q;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_term  = K_LAST;
    load      = 1'b0;
    start_enc = 1'b0;
    shift_enc = 1'b0;
    blk_idx   = '0;
    load_cout = 1'b0;
    en_out    = 1'b0;
    shift_out = 1'b0;
    rst_flag  = 1'b1;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (ready) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy   = 1'b1;
        load   = en_din;
        cnt_en = en_din;
        if (en_din && cnt_tc) state_d = ST_ENC_START;
      end
      ST_ENC_START: begin
        busy      = 1'b1;
        start_enc = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = ST_ENC;
      end
      ST_ENC: begin
        busy      = 1'b1;
        shift_enc = 1'b1;
        blk_idx   = cnt;
        cnt_en    = 1'b1;
        cnt_term  = P_LAST;
        if (cnt_tc) state_d = ST_LOAD_OUT;
      end
      ST_LOAD_OUT: begin
        busy      = 1'b1;
        load_cout = 1'b1;
        cnt_clr   = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        busy      = 1'b1;
        en_out    = 1'b1;
        shift_out = out_rdy;
        cnt_en    = out_rdy;
        cnt_term  = N_LAST;
        // Final transfer: clear the datapath and report completion next cycle.
        if (out_rdy && cnt_tc) begin
          rst_flag = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_control_encode.sv
// Randomised and directed bench for control_encode: a frame-progress model
// predicts every output each cycle, plus literal per-frame event counts.
module tb_control_encode;
  localparam int K = 8, P = 16, N = 16, CW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ready = 1'b0, en_din = 1'b0, out_rdy = 1'b0;
  logic load, start_enc, shift_enc, load_cout, en_out, shift_out, rst_flag, busy, done;
  logic [CW-1:0] blk_idx;

  control_encode #(.K_WORDS(K), .P_CYCLES(P), .N_WORDS(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .en_din(en_din), .out_rdy(out_rdy),
    .load(load), .start_enc(start_enc), .shift_enc(shift_enc), .blk_idx(blk_idx),
    .load_cout(load_cout), .en_out(en_out), .shift_out(shift_out),
    .rst_flag(rst_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Frame-progress model: how far the current frame has got.
  bit m_busy, m_started, m_cout, m_done;
  int m_loaded, m_steps, m_sent;

  // 0 idle, 1 loading, 2 parity clear, 3 parity steps, 4 codeword load, 5 output
  function automatic int phase();
    if (!m_busy)        return 0;
    if (m_loaded < K)   return 1;
    if (!m_started)     return 2;
    if (m_steps < P)    return 3;
    if (!m_cout)        return 4;
    return 5;
  endfunction

  always @(posedge clk) begin
    int ph;
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_started = 0; m_cout = 0; m_done = 0;
      m_loaded = 0; m_steps = 0; m_sent = 0;
    end else begin
      ph = phase();
      m_done = 0;
      case (ph)
        0: if (ready) begin
             m_busy = 1; m_started = 0; m_cout = 0;
             m_loaded = 0; m_steps = 0; m_sent = 0;
           end
        1: if (en_din) m_loaded++;
        2: m_started = 1;
        3: m_steps++;
        4: m_cout = 1;
        default: if (out_rdy) begin
             m_sent++;
             if (m_sent == N) begin m_busy = 0; m_done = 1; end
           end
      endcase
    end
  end

  // Per-frame event tallies taken from the DUT, checked against literals.
  int n_load, n_start, n_shen, n_cout, n_enout, n_shout, n_done, n_rstlow;
  int blk_sum, rstlow_idx, last_load_cyc, first_enout_cyc, start_cyc, last_shout_cyc;
  int done_cyc[$];
  int load_cyc[$];

  task automatic clear_counts();
    n_load = 0; n_start = 0; n_shen = 0; n_cout = 0; n_enout = 0; n_shout = 0;
    n_done = 0; n_rstlow = 0; blk_sum = 0; rstlow_idx = -1; last_load_cyc = -1;
    first_enout_cyc = -1; start_cyc = -1; last_shout_cyc = -1;
    done_cyc.delete(); load_cyc.delete();
  endtask

  always @(negedge clk) begin
    int ph;
    bit e_out, e_last;
    ph = rst_n ? phase() : 0;
    e_out  = (ph == 5);
    e_last = e_out && out_rdy && (m_sent == N - 1);
    chk("load",      load,      (ph == 1) && en_din);
    chk("start_enc", start_enc, ph == 2);
    chk("shift_enc", shift_enc, ph == 3);
    chk("blk_idx",   blk_idx,   (ph == 3) ? m_steps : 0);
    chk("load_cout", load_cout, ph == 4);
    chk("en_out",    en_out,    e_out);
    chk("shift_out", shift_out, e_out && out_rdy);
    chk("rst_flag",  rst_flag,  !e_last);
    chk("busy",      busy,      ph != 0);
    chk("done",      done,      rst_n && m_done);
    if (load)      begin n_load++; last_load_cyc = cyc; load_cyc.push_back(cyc); end
    if (start_enc) begin n_start++; start_cyc = cyc; end
    if (shift_enc) begin n_shen++; blk_sum += int'(blk_idx); end
    if (load_cout) n_cout++;
    if (en_out)    begin n_enout++; if (first_enout_cyc < 0) first_enout_cyc = cyc; end
    if (shift_out) begin n_shout++; last_shout_cyc = cyc; end
    if (!rst_flag) begin n_rstlow++; rstlow_idx = n_shout; end
    if (done)      begin n_done++; done_cyc.push_back(cyc); end
  end

  // Input driver: policies selected by the main process, applied mid-cycle.
  int mode_ready = 0, mode_din = 0, mode_rdy = 0, gap = 0;
  bit tog = 1;
  always @(posedge clk) begin
    #2;
    ready = (mode_ready == 1) || (mode_ready == 3 && ($urandom_range(0, 3) == 0));
    case (mode_din)
      1: en_din = 1'b1;
      2: en_din = (gap % 3 == 0);
      3: en_din = $urandom_range(0, 1) == 1;
      default: en_din = 1'b0;
    endcase
    gap++;
    case (mode_rdy)
      1: out_rdy = 1'b1;
      2: if (en_out) begin out_rdy = tog; tog = ~tog; end
         else begin out_rdy = 1'b0; tog = 1'b1; end
      3: out_rdy = $urandom_range(0, 2) != 0;
      default: out_rdy = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(int maxc, string nm);
    int k = 0;
    int d0 = n_done;
    while (n_done == d0 && k < maxc) begin step(); k++; end
    if (n_done == d0) begin
      checks++; failures++;
      $display("FAIL %s timeout after %0d cycles, no done", nm, maxc);
    end
  endtask

  task automatic pulse_ready();
    mode_ready = 1; step(); mode_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_counts();
    step(); step();
    chk("rst busy",     busy,     0);
    chk("rst rst_flag", rst_flag, 1);
    chk("rst blk_idx",  blk_idx,  0);
    chk("rst done",     done,     0);
    rst_n = 1'b1;
    step();

    // Single frame, continuous input, no back-pressure.
    clear_counts(); mode_din = 1; mode_rdy = 1;
    pulse_ready();
    wait_done(200, "basic");
    chk("basic n_load", n_load, 8);
    chk("basic n_start", n_start, 1);
    chk("basic n_shen", n_shen, 16);
    chk("basic blk_sum", blk_sum, 120);
    chk("basic n_cout", n_cout, 1);
    chk("basic n_shout", n_shout, 16);
    chk("basic n_done", n_done, 1);
    chk("basic latency", first_enout_cyc - last_load_cyc - 1, P + 2);
    chk("basic done_after_last", done_cyc[0] - last_shout_cyc, 1);
    chk("basic rstlow_idx", rstlow_idx, 16);
    step(); step();

    // Gapped message words.
    clear_counts(); mode_din = 2; gap = 0;
    pulse_ready();
    wait_done(300, "gapped");
    chk("gapped n_load", n_load, 8);
    chk("gapped start_after_8th", start_cyc - load_cyc[7], 1);
    step(); step();

    // Alternating downstream readiness.
    clear_counts(); mode_din = 1; mode_rdy = 2;
    pulse_ready();
    wait_done(300, "toggle");
    chk("toggle n_shout", n_shout, 16);
    chk("toggle n_enout", n_enout, 31);
    chk("toggle n_rstlow", n_rstlow, 1);
    chk("toggle rstlow_idx", rstlow_idx, 16);
    mode_rdy = 1;
    step(); step();

    // Reset during parity step 5, then a clean frame.
    clear_counts();
    pulse_ready();
    begin
      int k = 0;
      while (!(shift_enc === 1'b1 && blk_idx == 5) && k < 100) begin step(); k++; end
      chk("mid_reset reached step5", blk_idx, 5);
    end
    rst_n = 1'b0; #1;
    chk("mid_reset busy", busy, 0);
    chk("mid_reset shift_enc", shift_enc, 0);
    chk("mid_reset blk_idx", blk_idx, 0);
    chk("mid_reset rst_flag", rst_flag, 1);
    step(); step(); rst_n = 1'b1; step();
    clear_counts();
    pulse_ready();
    wait_done(200, "post_reset");
    chk("post_reset n_load", n_load, 8);
    chk("post_reset n_shout", n_shout, 16);
    chk("post_reset n_done", n_done, 1);
    step(); step();

    // Ready held high: back-to-back frames, stray inputs ignored mid-frame.
    clear_counts(); mode_ready = 1;
    wait_done(200, "b2b first");
    wait_done(200, "b2b second");
    chk("b2b n_load", n_load, 16);
    chk("b2b n_done", n_done, 2);
    chk("b2b load_after_done", load_cyc[8] - done_cyc[0], 1);
    mode_ready = 0;
    wait_done(200, "b2b drain");
    step(); step();

    // Random traffic, checked cycle by cycle against the model.
    mode_ready = 3; mode_din = 3; mode_rdy = 3;
    for (int f = 0; f < 6; f++) wait_done(600, "random");
    mode_ready = 0; mode_din = 0; mode_rdy = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
